// File: rtl/whack_pkg.sv
// whack_pkg: shared state encoding and constants for the whack-a-mole scheduler.
package whack_pkg;
    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
    localparam int NUM_HOLES = 9;
    localparam logic [3:0] POS_NONE = 4'd0;
    // key codes KEY_FIRST..KEY_LAST map onto holes 0..8
    localparam logic [3:0] KEY_FIRST = 4'd1;
    localparam logic [3:0] KEY_LAST = 4'd9;
    localparam int LIFE_MIN = 16;
    localparam int SPEEDUP_STEP = 8;
    localparam int SPEEDUP_HITS = 10;
    function automatic logic key_valid(input logic [3:0] pos);
        return pos != POS_NONE && pos >= KEY_FIRST && pos <= KEY_LAST;
    endfunction
endpackage

// File: rtl/mole_lfsr.sv
// mole_lfsr: free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), low nibble exposed.
module mole_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] rnd
);
    logic [15:0] state;
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= SEED;
        else state <= {1'b0, state[15:1]} ^ (state[0] ? 16'hB400 : 16'h0000);
    assign rnd = state[3:0];
endmodule

// File: rtl/mole_scheduler.sv
// mole_scheduler: mole spawning, lifetimes, hit judging and round timer for whack-a-mole.
// Optional MOLE_SPEEDUP_EN shortens mole life by 8 ticks every 10 hits (floor 16).
module mole_scheduler
    import whack_pkg::*;
#(
    parameter int TICK_DIV = 1_000_000,
    parameter int SPAWN_TICKS = 50,
    parameter int LIFE_TICKS = 80,
    parameter int MAX_MOLES = 3,
    parameter int GAME_TICKS = 3000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_game,
    input  logic [3:0]  one_pulse_pos,
    output logic [8:0]  map,
    output logic        hit_pulse,
    output logic        miss_pulse,
    output logic        timeout_pulse,
    output logic        game_active,
    output logic [11:0] time_left
);
    localparam int DIV_W = $clog2(TICK_DIV + 1);
    localparam int SPW = $clog2(SPAWN_TICKS + 1);

    state_t state, state_nxt;
    logic [DIV_W-1:0] div;
    logic [SPW-1:0] spawn_cnt;
    logic [6:0] life [NUM_HOLES];
    logic [6:0] life_load;
    logic [3:0] rnd, cand, hole, pop, spawn_idx, scan_idx;
    logic [4:0] scan_sum;
    logic [8:0] key_mask, hit_mask, exp_mask, spawn_mask, map_nxt;
    logic tick, key_ok, last_tick, spawn_due, run_go;

    mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .rnd(rnd));

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        tick = state == RUN && div == DIV_W'(TICK_DIV - 1);
        last_tick = tick && time_left == 12'd1;
        state_nxt = start_game ? RUN : (state == RUN && last_tick) ? OVER : state;
        run_go = state == RUN && !start_game && !last_tick;
        key_ok = state == RUN && key_valid(one_pulse_pos);
        hole = one_pulse_pos - KEY_FIRST;
        key_mask = key_ok ? (9'd1 << hole) : 9'd0;
        hit_mask = key_mask & map;
        pop = 4'd0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            exp_mask[i] = tick && map[i] && life[i] == 7'd1;
            pop = pop + {3'd0, map[i]};
        end
        spawn_due = tick && spawn_cnt == SPW'(SPAWN_TICKS - 1) && pop < 4'(MAX_MOLES);
        cand = rnd >= 4'd9 ? rnd - 4'd9 : rnd;
        // scan from the far end so the nearest free hole after cand wins; hit/expiring holes stay occupied
        spawn_idx = 4'd0;
        scan_sum = 5'd0;
        scan_idx = 4'd0;
        for (int k = NUM_HOLES - 1; k >= 0; k--) begin
            scan_sum = {1'b0, cand} + 5'(k);
            scan_idx = scan_sum >= 5'd9 ? 4'(scan_sum - 5'd9) : scan_sum[3:0];
            if (!map[scan_idx]) spawn_idx = scan_idx;
        end
        spawn_mask = spawn_due ? (9'd1 << spawn_idx) : 9'd0;
        map_nxt = (map & ~hit_mask & ~exp_mask) | spawn_mask;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            map <= 9'd0;
            hit_pulse <= 1'b0;
            miss_pulse <= 1'b0;
            timeout_pulse <= 1'b0;
            game_active <= 1'b0;
            time_left <= 12'd0;
            div <= '0;
            spawn_cnt <= '0;
            for (int i = 0; i < NUM_HOLES; i++) life[i] <= 7'd0;
        end else begin
            game_active <= state_nxt == RUN;
            hit_pulse <= run_go && |hit_mask;
            miss_pulse <= run_go && key_ok && ~|hit_mask;
            timeout_pulse <= run_go && |(exp_mask & ~hit_mask);
            if (start_game) begin
                map <= 9'd0;
                div <= '0;
                spawn_cnt <= '0;
                time_left <= 12'(GAME_TICKS);
            end else if (state == RUN) begin
                map <= last_tick ? 9'd0 : map_nxt;
                div <= tick ? '0 : div + 1'b1;
                if (tick) begin
                    time_left <= time_left - 12'd1;
                    spawn_cnt <= spawn_cnt == SPW'(SPAWN_TICKS - 1) ? '0 : spawn_cnt + 1'b1;
                end
            end
            for (int i = 0; i < NUM_HOLES; i++)
                life[i] <= spawn_mask[i] ? life_load : (tick && map[i]) ? life[i] - 7'd1 : life[i];
        end
    end

`ifdef MOLE_SPEEDUP_EN
    logic [3:0] hit_cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt <= 4'd0;
            life_load <= 7'(LIFE_TICKS);
        end else if (start_game) begin
            hit_cnt <= 4'd0;
            life_load <= 7'(LIFE_TICKS);
        end else if (state == RUN && |hit_mask) begin
            hit_cnt <= hit_cnt == 4'(SPEEDUP_HITS - 1) ? 4'd0 : hit_cnt + 4'd1;
            if (hit_cnt == 4'(SPEEDUP_HITS - 1))
                life_load <= life_load > 7'(LIFE_MIN + SPEEDUP_STEP) ? life_load - 7'(SPEEDUP_STEP) :
                             life_load > 7'(LIFE_MIN) ? 7'(LIFE_MIN) : life_load;
        end
    end
`else
    assign life_load = 7'(LIFE_TICKS);
`endif
endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: randomized self-checking bench against a tick/deadline reference model.
module tb_mole_scheduler;
    localparam int TICK_DIV = 4;
    localparam int SPAWN = 2;
    localparam int MAXM = 3;
    localparam int GAME = 100;
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef MOLE_SPEEDUP_EN
    localparam int LIFE = 24;
`else
    localparam int LIFE = 5;
`endif

    logic clk = 1'b0, rst = 1'b0, start_game = 1'b0;
    logic [3:0] one_pulse_pos = 4'd0;
    logic [8:0] map;
    logic hit_pulse, miss_pulse, timeout_pulse, game_active;
    logic [11:0] time_left;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    mole_scheduler #(.TICK_DIV(TICK_DIV), .SPAWN_TICKS(SPAWN), .LIFE_TICKS(LIFE),
                     .MAX_MOLES(MAXM), .GAME_TICKS(GAME), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start_game(start_game), .one_pulse_pos(one_pulse_pos),
        .map(map), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
        .timeout_pulse(timeout_pulse), .game_active(game_active), .time_left(time_left));

    // reference model: round progress in ticks, each raised mole keeps its absolute expiry tick
    bit m_run, m_hit, m_miss, m_to;
    bit [8:0] m_up;
    int m_cyc, m_ticks, m_hits, m_time;
    int m_dead [9];
    logic [15:0] m_lfsr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] taps = (1 << 15) | (1 << 13) | (1 << 12) | (1 << 10);
        return v[0] ? (v >> 1) ^ taps : v >> 1;
    endfunction

    function automatic int life_now();
`ifdef MOLE_SPEEDUP_EN
        int l = LIFE - 8 * (m_hits / 10);
        return (m_hits < 10) ? LIFE : (l < 16 ? 16 : l);
`else
        return LIFE;
`endif
    endfunction

    task automatic model_reset();
        m_run = 0; m_hit = 0; m_miss = 0; m_to = 0; m_up = 0;
        m_time = 0; m_hits = 0; m_lfsr = SEED;
    endtask

    task automatic model_step(input bit st, input logic [3:0] p);
        logic [15:0] lf = m_lfsr;
        bit [8:0] nu;
        bit tick;
        int cand, pick;
        m_lfsr = lfsr_step(m_lfsr);
        m_hit = 0; m_miss = 0; m_to = 0;
        if (st) begin
            m_run = 1; m_cyc = 0; m_ticks = 0; m_up = 0; m_hits = 0; m_time = GAME;
            return;
        end
        if (!m_run) return;
        m_cyc++;
        tick = (m_cyc % TICK_DIV) == 0;
        if (tick) m_ticks++;
        nu = m_up;
        if (p >= 1 && p <= 9) begin
            if (m_up[p - 1]) begin m_hit = 1; nu[p - 1] = 0; end
            else m_miss = 1;
        end
        if (tick) begin
            for (int i = 0; i < 9; i++)
                if (nu[i] && m_dead[i] == m_ticks) begin nu[i] = 0; m_to = 1; end
            if (m_ticks % SPAWN == 0 && $countones(m_up) < MAXM) begin
                cand = int'(lf[3:0]) % 9;
                pick = -1;
                for (int k = 0; k < 9; k++)
                    if (pick < 0 && !m_up[(cand + k) % 9]) pick = (cand + k) % 9;
                nu[pick] = 1;
                m_dead[pick] = m_ticks + life_now();
            end
        end
        if (m_hit) m_hits++;
        if (tick && m_ticks == GAME) begin
            m_run = 0; nu = 0; m_hit = 0; m_miss = 0; m_to = 0; m_time = 0;
        end else m_time = GAME - m_ticks;
        m_up = nu;
    endtask

    function automatic logic [3:0] pick_key();
        int r = $urandom_range(99);
        int off = $urandom_range(8);
        if (m_run && ((m_cyc + 1) % TICK_DIV) == 0 && r < 60)
            for (int i = 0; i < 9; i++)
                if (m_up[i] && m_dead[i] == m_ticks + 1) return 4'(i + 1);
        if (r < 30 && m_up != 0)
            for (int k = 0; k < 9; k++)
                if (m_up[(off + k) % 9]) return 4'((off + k) % 9 + 1);
        if (r < 45) return 4'($urandom_range(15));
        return 4'd0;
    endfunction

    task automatic cycle(input bit st, input logic [3:0] p);
        start_game = st;
        one_pulse_pos = p;
        model_step(st, p);
        @(posedge clk);
        #1;
        check("map", 32'(map), 32'(m_up));
        check("hit_pulse", 32'(hit_pulse), 32'(m_hit));
        check("miss_pulse", 32'(miss_pulse), 32'(m_miss));
        check("timeout_pulse", 32'(timeout_pulse), 32'(m_to));
        check("game_active", 32'(game_active), 32'(m_run));
        check("time_left", 32'(time_left), 32'(m_time));
        check("max_moles", 32'($countones(map) <= MAXM), 32'd1);
        @(negedge clk);
        start_game = 1'b0;
        one_pulse_pos = 4'd0;
    endtask

    task automatic async_reset();
        #1 rst = 1'b0;
        #1;
        check("rst_map", 32'(map), 32'd0);
        check("rst_active", 32'(game_active), 32'd0);
        check("rst_time", 32'(time_left), 32'd0);
        #1 rst = 1'b1;
        model_reset();
    endtask

    initial begin
        int h;
        model_reset();
        repeat (2) @(negedge clk);
        check("init_map", 32'(map), 32'd0);
        check("init_active", 32'(game_active), 32'd0);
        check("init_time", 32'(time_left), 32'd0);
        check("init_pulses", 32'({hit_pulse, miss_pulse, timeout_pulse}), 32'd0);
        rst = 1'b1;
        repeat (3) cycle(0, 4'd0);
        cycle(1, 4'd0);
        check("start_time", 32'(time_left), 32'(GAME));
        repeat (7) cycle(0, 4'd0);
        check("no_early_spawn", 32'($countones(map)), 32'd0);
        cycle(0, 4'd0);
        check("first_spawn", 32'($countones(map)), 32'd1);
        h = 0;
        for (int i = 8; i >= 0; i--) if (m_up[i]) h = i;
        cycle(0, 4'(h + 1));
        check("hit_clears", 32'(map[h]), 32'd0);
        check("hit_once_a", 32'(hit_pulse), 32'd1);
        cycle(0, 4'd0);
        check("hit_once_b", 32'(hit_pulse), 32'd0);
        cycle(0, 4'(h + 1));
        check("miss_after_hit", 32'(miss_pulse), 32'd1);
        for (int n = 0; n < 100 && $countones(m_up) < 2; n++) cycle(0, 4'd0);
        check("two_moles_up", 32'($countones(map) >= 2), 32'd1);
        async_reset();
        repeat (3) cycle(0, 4'd0);
        cycle(1, 4'd0);
        repeat (450) cycle(0, pick_key());
        check("over_active", 32'(game_active), 32'd0);
        check("over_map", 32'(map), 32'd0);
        repeat (30) cycle(0, 4'($urandom_range(15)));
        cycle(1, 4'd0);
        check("restart_time", 32'(time_left), 32'(GAME));
        repeat (2500) cycle($urandom_range(399) == 0, pick_key());
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
- Generates the 9-hole mole map for the whack-a-mole game and judges hits.
- Consumes the one-pulse key position from the keyboard interface and the debounced start pulse.
- Drives the 9-bit map consumed by the game controller/display path, plus hit/miss/timeout pulses consumed by scoring and audio.
- Owns the spawn pacing, the per-mole lifetime counters and the game-duration timer.

Parameters:
TICK_DIV, 1_000_000, clk cycles per game tick (10 ms at 100 MHz)
SPAWN_TICKS, 50, ticks between spawn attempts
LIFE_TICKS, 80, ticks a mole stays up unless hit (1..127)
MAX_MOLES, 3, max simultaneously raised moles (1..9)
GAME_TICKS, 3000, ticks per game round
LFSR_SEED, 16'hACE1, nonzero LFSR reset value

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start_game  in  1  one-cycle start pulse
one_pulse_pos  in  4  one-cycle key code: 0 = none, 1..9 = hole 0..8, 10..15 ignored
map  out  9  bit i = mole raised in hole i
hit_pulse  out  1  one cycle, valid key on raised hole
miss_pulse  out  1  one cycle, valid key on empty hole
timeout_pulse  out  1  one cycle, a mole expired unhit
game_active  out  1  high in RUN
time_left  out  12  remaining ticks of the round

Behaviour:
- Reset (rst=0, async): state IDLE; map=0; all pulses 0; game_active=0; time_left=0; LFSR=LFSR_SEED; all counters 0.
- LFSR (Galois, x^16+x^14+x^13+x^11+1) advances every clk in every state, so the seed depends on start timing.
- States IDLE, RUN, OVER:
  - IDLE/OVER -start_game-> RUN.
  - RUN -start_game-> RUN (restart).
  - RUN -time_left reaches 0-> OVER.
- Entering RUN clears map, the tick divider and the spawn counter; sets time_left=GAME_TICKS.
- tick: one-cycle strobe every TICK_DIV cycles. The divider runs only in RUN.
- On each tick in RUN:
  - time_left decrements.
  - Every raised hole's life counter decrements. A counter going 1->0 clears its map bit. timeout_pulse is asserted if any hole expired that tick; multiple expiries give one pulse.
  - Spawn counter increments; on reaching SPAWN_TICKS it resets to 0 and a spawn attempt occurs.
- Spawn attempt:
  - Skipped if popcount(map) >= MAX_MOLES.
  - cand = lfsr[3:0], minus 9 if >= 9.
  - Pick the first free hole scanning cand, cand+1, ... wrapping mod 9. Set its bit and load life counter with LIFE_TICKS.
  - A hole expiring or being hit this cycle counts as occupied for the scan.
- Hit judging, RUN only, any cycle:
  - one_pulse_pos in 1..9 with map bit set: clear the bit, hit_pulse=1 next cycle.
  - Bit clear: miss_pulse=1 next cycle.
  - Codes 0 and 10..15: no action.
- Simultaneous events on the same hole: hit beats expiry (hit_pulse only, no timeout_pulse). Spawn never lands on a hole hit or expired the same cycle.
- All outputs registered; map reflects a hit/spawn/expiry one cycle after the causing event. Pulse latency is 1 cycle.
- OVER: map=0, no pulses, key input ignored, time_left=0.
- IDLE: same as OVER.
- game_active=1 exactly in RUN.

Optional Feature:
- Macro MOLE_SPEEDUP_EN.
- When defined: an internal hit counter is cleared on RUN entry. Every 10th hit reduces the effective life load value by 8 ticks, floor 16. Only subsequent spawns are affected.
- When undefined: life load is always LIFE_TICKS, and the hit counter is not built.

Decomposition:
- Shared package whack_pkg:
  - state enum (IDLE, RUN, OVER);
  - NUM_HOLES=9;
  - POS_NONE=4'd0;
  - key-code-to-hole mapping constant;
  - LIFE_MIN=16, SPEEDUP_STEP=8, SPEEDUP_HITS=10.
- One sub-module, mole_lfsr: 16-bit Galois LFSR with seed parameter, free-running, async active-low reset.

Test Plan:
Bench parameters: TICK_DIV=4, SPAWN_TICKS=2, LIFE_TICKS=5, MAX_MOLES=3, GAME_TICKS=100.
1. Reset mid-RUN with 2 moles up -> map=0, game_active=0, time_left=0 asynchronously; no pulses after release.
2. start_game, no keys -> first spawn after 2 ticks (8 clk); each mole clears 5 ticks after spawn with one timeout_pulse; popcount(map) never exceeds 3.
3. Mole at hole 4, one_pulse_pos=5 -> map[4] clears next cycle, hit_pulse for exactly 1 cycle; one_pulse_pos=5 again -> miss_pulse.
4. Same-cycle key on hole whose life counter hits 0 -> hit_pulse=1, timeout_pulse=0. Force cand=8 with holes 8,0 full -> spawn lands on hole 1.
5. one_pulse_pos=12 and 0 in RUN -> no pulse, map unchanged. Keys in OVER -> no pulse.
6. Run 100 ticks -> OVER, map=0, game_active=0. start_game -> RUN with time_left=100. With MOLE_SPEEDUP_EN and LIFE_TICKS=24: after 10 hits, new moles live 16 ticks; after 20 hits, still 16.
